// File: rtl/pic_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_prog_loader_if
// Description : Program-memory write port between the serial loader and the
//               PIC16 program memory.
//   PM_WE    write strobe, one cycle per word
//   PM_ADDR  write address (ADDR_W bits)
//   PM_DATA  14-bit instruction word
//   master : loader side (drives the port)
//   slave  : memory side (observes the port)
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_prog_loader_if #(
  parameter int ADDR_W = 11
);
  logic              PM_WE;
  logic [ADDR_W-1:0] PM_ADDR;
  logic [13:0]       PM_DATA;

  modport master (output PM_WE, PM_ADDR, PM_DATA);
  modport slave  (input  PM_WE, PM_ADDR, PM_DATA);
endinterface
`default_nettype wire

// File: rtl/pic_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : pic_prog_loader
// Description : Serial program loader for the PIC16 core. Receives a framed
//               program image on an 8N1 UART line, writes 14-bit words into
//               program memory and holds the core in reset while loading.
//   CLK       in   PIC clock, rising edge
//   nRST      in   asynchronous active-low reset
//   RXD       in   UART receive line (asynchronous, idle high)
//   pm        if   program-memory write port (master)
//   CORE_RST  out  active-high core reset request
//   BUSY      out  a load frame is in progress
//   ERR       out  last load failed (sticky until the next sync byte)
// Revision    : 1.0 - initial release
// ============================================================================
module pic_prog_loader #(
  parameter int CLKDIV        = 608,
  parameter int ADDR_W        = 11,
  parameter bit HOLD_AT_RESET = 1'b0
) (
  input  wire logic         CLK,
  input  wire logic         nRST,
  input  wire logic         RXD,
  pic_prog_loader_if.master pm,
  output logic              CORE_RST,
  output logic              BUSY,
  output logic              ERR
);

  localparam int               CNT_W     = $clog2(CLKDIV);
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(CLKDIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(CLKDIV - 1);
  localparam logic [7:0]       C_SYNC    = 8'hA5;

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;
  // rxd_s3_q is one cycle behind the synchronized line, for edge detection
  logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    if (rx_state_q != RX_IDLE) begin
      rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_s3_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = C_HALF_M1;
        end
      end
      RX_START: begin
        // mid-bit resample: a high line means the edge was a glitch
        if (rx_cnt_q == '0) begin
          if (rxd_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = C_FULL_M1;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = C_FULL_M1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rxd_s2_q) begin
            rx_valid_d = 1'b1;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Loader FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNT_L = 3'd1,
    ST_CNT_H = 3'd2,
    ST_W_LO  = 3'd3,
    ST_W_HI  = 3'd4,
    ST_CSUM  = 3'd5
  } ld_state_t;

  ld_state_t         state_q, state_d;
  logic [15:0]       remain_q, remain_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        lo_q, lo_d;
  // wptr_q is the address of the next word; addr_q is what the port shows,
  // so PM_ADDR holds the address of the last write until the next one
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [13:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        w_sum_next;

  assign w_sum_next = sum_q + rx_shift_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      sum_q      <= '0;
      lo_q       <= '0;
      wptr_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      core_rst_q <= HOLD_AT_RESET;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      sum_q      <= sum_d;
      lo_q       <= lo_d;
      wptr_q     <= wptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    sum_d      = sum_q;
    lo_d       = lo_q;
    wptr_d     = wptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    core_rst_d = core_rst_q;
    busy_d     = busy_q;
    err_d      = err_q;
    if (rx_ferr_q && (state_q != ST_IDLE)) begin
      // abort: core stays held in reset until a later load succeeds
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      core_rst_d = 1'b1;
      busy_d     = 1'b0;
    end else if (rx_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_shift_q == C_SYNC) begin
            state_d    = ST_CNT_L;
            core_rst_d = 1'b1;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            addr_d     = '0;
            wptr_d     = '0;
            sum_d      = '0;
          end
        end
        ST_CNT_L: begin
          remain_d[7:0] = rx_shift_q;
          sum_d         = w_sum_next;
          state_d       = ST_CNT_H;
        end
        ST_CNT_H: begin
          remain_d[15:8] = rx_shift_q;
          sum_d          = w_sum_next;
          state_d        = ({rx_shift_q, remain_q[7:0]} == 16'd0) ? ST_CSUM : ST_W_LO;
        end
        ST_W_LO: begin
          lo_d    = rx_shift_q;
          sum_d   = w_sum_next;
          state_d = ST_W_HI;
        end
        ST_W_HI: begin
          we_d     = 1'b1;
          addr_d   = wptr_q;
          wptr_d   = wptr_q + ADDR_W'(1);
          data_d   = {rx_shift_q[5:0], lo_q};
          sum_d    = w_sum_next;
          remain_d = remain_q - 16'd1;
          state_d  = (remain_q == 16'd1) ? ST_CSUM : ST_W_LO;
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (w_sum_next == 8'd0) begin
            core_rst_d = 1'b0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pm.PM_WE   = we_q;
  assign pm.PM_ADDR = addr_q;
  assign pm.PM_DATA = data_q;
  assign CORE_RST   = core_rst_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_prog_loader
// Description : Self-checking bench for pic_prog_loader. A frame-level model
//               predicts the program-memory writes and the final status for
//               each frame; a compare process checks every write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_prog_loader;

  localparam int CLKDIV = 16;
  localparam int ADDR_W = 4;
  localparam bit HOLD   = 1'b0;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic rxd  = 1'b1;
  logic core_rst, busy, err;

  pic_prog_loader_if #(.ADDR_W(ADDR_W)) pm ();

  pic_prog_loader #(
    .CLKDIV        (CLKDIV),
    .ADDR_W        (ADDR_W),
    .HOLD_AT_RESET (HOLD)
  ) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .RXD      (rxd),
    .pm       (pm),
    .CORE_RST (core_rst),
    .BUSY     (busy),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         exp_q[$];
  wr_t         log_q[$];
  logic [7:0]  frame_q[$];
  bit          m_core_rst = HOLD;
  bit          m_err      = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // every write strobe must match the next predicted write
  always @(negedge clk) begin
    wr_t w;
    if (!nrst) begin
      check("we_in_reset", {31'd0, pm.PM_WE}, 32'd0);
    end else begin
      if (busy === 1'b1) check("core_rst_while_busy", {31'd0, core_rst}, 32'd1);
      if (pm.PM_WE !== 1'b0) begin
        w.addr = {{(32-ADDR_W){1'b0}}, pm.PM_ADDR};
        w.data = {18'd0, pm.PM_DATA};
        log_q.push_back(w);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          check("wr_addr", w.addr, exp_q[0].addr);
          check("wr_data", w.data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CLKDIV) @(posedge clk);
  endtask

  // drives the first nbits bit-times of a UART frame (10 = whole byte)
  task automatic uart_byte(input logic [7:0] b, input bit stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = fr[i];
      repeat (CLKDIV) @(posedge clk);
    end
    if (!stop && nbits == 10) idle_bits(1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, m_core_rst});
    check({tag, "_err"},      {31'd0, err},      {31'd0, m_err});
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_pending"},  exp_q.size(),      32'd0);
    exp_q.delete();
  endtask

  // sends frame_q; ferr_idx >= 0 sends that byte with a bad stop bit and
  // abandons the rest of the frame
  task automatic run_frame(input int ferr_idx, input string tag);
    int         n;
    int         last;
    logic [7:0] s;
    logic [7:0] lo;
    logic [7:0] hi;
    bit         started;
    wr_t        w;
    started = (ferr_idx != 0);
    n       = {16'd0, frame_q[2], frame_q[1]};
    last    = (ferr_idx < 0) ? frame_q.size() : ferr_idx;
    if (started) begin
      for (int j = 0; j < n; j++) begin
        if (4 + 2 * j < last) begin
          lo     = frame_q[3 + 2 * j];
          hi     = frame_q[4 + 2 * j];
          w.addr = j % (1 << ADDR_W);
          w.data = {18'd0, hi[5:0], lo};
          exp_q.push_back(w);
        end
      end
      s = 8'd0;
      for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
      if (ferr_idx < 0) begin
        m_core_rst = (s != 8'd0);
        m_err      = (s != 8'd0);
      end else begin
        m_core_rst = 1'b1;
        m_err      = 1'b1;
      end
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == ferr_idx) begin
        uart_byte(frame_q[i], 1'b0, 10);
        break;
      end
      uart_byte(frame_q[i], 1'b1, 10);
      if (i == 0 && started) begin
        check({tag, "_busy_rise"},     {31'd0, busy},     32'd1);
        check({tag, "_core_rst_rise"}, {31'd0, core_rst}, 32'd1);
      end
    end
    idle_bits(3);
    check_status(tag);
  endtask

  task automatic build_frame(input int n, input bit good);
    logic [7:0] s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    for (int j = 0; j < 2 * n; j++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
    end
    s = 8'd0;
    for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
    b = 8'd0 - s;
    if (!good) b = b + 8'($urandom_range(1, 255));
    frame_q.push_back(b);
  endtask

  task automatic load_good();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h28, 8'h00, 8'h00, 8'hD1};
  endtask

  initial begin
    int n;
    int fe;
    logic [7:0] g;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",       {31'd0, pm.PM_WE},  32'd0);
    check("rst_addr",     {28'd0, pm.PM_ADDR}, 32'd0);
    check("rst_data",     {18'd0, pm.PM_DATA}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst},  {31'd0, HOLD});
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_err",      {31'd0, err},       32'd0);
    @(negedge clk);
    nrst = 1'b1;
    idle_bits(2);

    // good load, with literal expectations on the logged writes
    log_q.delete();
    load_good();
    run_frame(-1, "good");
    check("good_nwr", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      check("good_a0", log_q[0].addr, 32'h0);
      check("good_d0", log_q[0].data, 32'h2805);
      check("good_a1", log_q[1].addr, 32'h1);
      check("good_d1", log_q[1].data, 32'h0000);
    end
    check("good_core_rst_lit", {31'd0, core_rst}, 32'd0);

    // bad checksum, then recovery
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h28, 8'h00, 8'h00, 8'hD2};
    run_frame(-1, "badcs");
    check("badcs_err_lit", {31'd0, err}, 32'd1);
    load_good();
    run_frame(-1, "recover");

    // framing error on NH, then ignored noise bytes
    load_good();
    run_frame(2, "ferr");
    check("ferr_err_lit", {31'd0, err}, 32'd1);
    uart_byte(8'h00, 1'b1, 10);
    uart_byte(8'hFF, 1'b1, 10);
    uart_byte(8'h5A, 1'b1, 10);
    idle_bits(2);
    check_status("ferr_noise");

    // noise in idle with the core running
    load_good();
    run_frame(-1, "pre_noise");
    uart_byte(8'h00, 1'b1, 10);
    uart_byte(8'hFF, 1'b1, 10);
    uart_byte(8'h5A, 1'b1, 10);
    idle_bits(2);
    check_status("noise");

    // short glitch must not start a byte that would swallow the next frame
    rxd = 1'b0;
    repeat (CLKDIV / 4) @(posedge clk);
    idle_bits(1);
    load_good();
    run_frame(-1, "glitch");

    // empty image
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(-1, "empty");

    // reset while waiting for a high byte
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h05};
    for (int i = 0; i < frame_q.size(); i++) uart_byte(frame_q[i], 1'b1, 10);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    uart_byte(8'h28, 1'b1, 6);
    nrst = 1'b0;
    #1;
    check("midrst_we",       {31'd0, pm.PM_WE},   32'd0);
    check("midrst_addr",     {28'd0, pm.PM_ADDR}, 32'd0);
    check("midrst_data",     {18'd0, pm.PM_DATA}, 32'd0);
    check("midrst_core_rst", {31'd0, core_rst},   {31'd0, HOLD});
    check("midrst_busy0",    {31'd0, busy},       32'd0);
    check("midrst_err",      {31'd0, err},        32'd0);
    m_core_rst = HOLD;
    m_err      = 1'b0;
    rxd        = 1'b1;
    repeat (CLKDIV) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    idle_bits(2);
    load_good();
    run_frame(-1, "after_rst");

    // randomized frames; the first one wraps the address space
    for (int k = 0; k < 8; k++) begin
      for (int q = 0; q < int'($urandom_range(0, 2)); q++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        uart_byte(g, 1'($urandom_range(0, 1)), 10);
      end
      n = (k == 0) ? 18 : int'($urandom_range(0, 12));
      build_frame(n, $urandom_range(0, 3) != 0);
      fe = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, frame_q.size() - 1)) : -1;
      run_frame(fe, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_prog_loader.md
# pic_prog_loader

Serial program loader for the PIC16 FPGA core. It receives a framed program image over an 8N1 UART line, writes 14-bit instruction words into the program-memory write port, and holds the core in reset while loading. It sits beside the core in the top level: it drives the program-memory write port and ORs into the core reset, so firmware can be replaced without rebuilding the bitstream.

## Interface
- CLKDIV, 608: PIC clock cycles per UART bit (70 MHz / 115200); must be at least 16.
- ADDR_W, 11: program-memory address width.
- HOLD_AT_RESET, 0: reset value of CORE_RST. When 0, the core runs the preloaded image after reset.
- CLK  in  1  PIC clock; all logic on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- RXD  in  1  UART receive line, asynchronous to CLK, idle high.
- PM_WE  out  1  program-memory write strobe, one cycle per word.
- PM_ADDR  out  ADDR_W  write address.
- PM_DATA  out  14  instruction word to write.
- CORE_RST  out  1  active-high core reset request.
- BUSY  out  1  a load frame is in progress.
- ERR  out  1  the last load failed (framing error or bad checksum); sticky until the next 0xA5.

## Operation
- Frame bytes, in order:
  - 0xA5 sync byte.
  - NL, NH: word count N, 16-bit, low byte first.
  - N words, each sent as a low byte then a high byte.
  - CS checksum byte: the 8-bit sum of NL through CS must equal 0x00.
- Word assembly:
  - PM_DATA = {high[5:0], low[7:0]}.
  - High-byte bits 7:6 are discarded but still count in the checksum.
- UART receiver:
  - RXD passes through a 2-flop synchronizer.
  - A falling edge on the synchronized line starts a bit counter.
  - The start bit is resampled at CLKDIV/2; if it reads high, the edge is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKDIV cycles, LSB first.
  - The stop bit is sampled one CLKDIV later. A stop bit of 1 delivers the byte; a stop bit of 0 is a framing error.
- Loader FSM states: IDLE, CNT_L, CNT_H, W_LO, W_HI, CSUM.
  - IDLE: 0xA5 → CNT_L. Any other byte is ignored.
  - CNT_L → CNT_H on the next byte.
  - CNT_H: if N = 0, go to CSUM; otherwise go to W_LO.
  - W_LO → W_HI on the next byte.
  - W_HI: pulse PM_WE, then decrement the remaining count. If the count reaches 0, go to CSUM; otherwise go to W_LO.
  - CSUM: sum = 0 → release CORE_RST and clear ERR. Sum ≠ 0 → set ERR and keep CORE_RST asserted. In both cases return to IDLE.
- Accepting 0xA5 in IDLE always starts a new load, including while the core is running. It:
  - asserts CORE_RST and BUSY;
  - clears ERR;
  - sets PM_ADDR to 0;
  - clears the running sum.
- A framing error in any state other than IDLE sets ERR, returns the FSM to IDLE, keeps CORE_RST at 1 and clears BUSY. A framing error in IDLE is ignored.
- PM_ADDR increments after each write and wraps modulo 2^ADDR_W; words past the top overwrite from address 0.
- Words already written are not retracted on error. CORE_RST stays at 1 until a later load succeeds.

## Timing
- Reset values: PM_WE 0, PM_ADDR 0, PM_DATA 0, CORE_RST = HOLD_AT_RESET, BUSY 0, ERR 0. The receiver and FSM reset to idle.
- nRST acts immediately: asserting it mid-frame aborts the load with no further PM_WE.
- Byte delivery: one cycle after the stop-bit sample, i.e. about 2 + 9.5·CLKDIV cycles after the RXD falling edge.
- A new start edge is accepted from the cycle after the stop-bit sample, so back-to-back bytes with no idle gap are supported.
- PM_WE is high for exactly one cycle, the cycle after the high byte is delivered. PM_ADDR and PM_DATA are stable during that cycle and hold their values until the next write.
- CORE_RST and BUSY rise the cycle after 0xA5 is delivered.
- After CS is delivered, BUSY falls the next cycle. In the same cycle CORE_RST falls (good checksum) or ERR rises (bad checksum).

## Test plan
- Good load: A5 02 00 05 28 00 00 D1 → PM_WE at addr 0 with 0x2805, then at addr 1 with 0x0000; CORE_RST falls; ERR stays 0; BUSY falls.
- Bad checksum: same frame ending in D2 → both writes occur; ERR = 1; CORE_RST stays 1. A following good frame clears ERR and releases CORE_RST.
- Framing error: drive stop bit = 0 on the NH byte → ERR = 1, BUSY = 0, no PM_WE. Subsequent non-A5 bytes are ignored.
- Noise in IDLE:
  - bytes 0x00, 0xFF, 0x5A → no state change;
  - a low pulse of CLKDIV/4 on RXD → no byte delivered.
- Empty image: A5 00 00 00 → no PM_WE; CORE_RST released one cycle after CS.
- Reset mid-load: assert nRST during W_HI → all outputs at reset values immediately, with no PM_WE. After deassertion, the good-load frame completes correctly.
